// File: rtl/rs_encoder_serial.sv
// Systematic RS(7,5) encoder over GF(8) (x^3+x+1).
// Message symbols arrive serially, first symbol = highest-degree coefficient,
// and run through a two-register parity LFSR for g(x) = x^2 + G1*x + G0.
// The finished codeword {message, p1, p0} is held on a valid/ready output.
// Symbol bit[2] is the coefficient of 1, bit[1] of alpha, bit[0] of alpha^2.
module rs_encoder_serial #(
    parameter int SYMBOL_WIDTH = 3,
    parameter int N            = 7,
    parameter int K            = 5,
    parameter logic [SYMBOL_WIDTH-1:0] G0 = 3'b110,
    parameter logic [SYMBOL_WIDTH-1:0] G1 = 3'b011
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        abort,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [SYMBOL_WIDTH-1:0]     in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [N*SYMBOL_WIDTH-1:0]   out_codeword
);

    localparam int MW    = K * SYMBOL_WIDTH;
    localparam int CNT_W = $clog2(K);

    typedef logic [SYMBOL_WIDTH-1:0] sym_t;
    typedef enum logic {LOAD, HOLD} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    sym_t             r0, r1;
    logic [MW-1:0]    msg;

    sym_t             fb, r0_nxt, r1_nxt;
    logic [MW-1:0]    msg_nxt;
    logic             accept;

    // Multiply by alpha: alpha^3 folds back to 1 + alpha.
    function automatic sym_t gf_mul_a(input sym_t s);
        return {s[0], s[2] ^ s[0], s[1]};
    endfunction

    // Shift-and-add multiply; b[2-i] is the alpha^i coefficient of b.
    function automatic sym_t gf_mul(input sym_t a, input sym_t b);
        sym_t acc;
        sym_t p;
        acc = '0;
        p   = a;
        for (int i = 0; i < 3; i++) begin
            if (b[2-i]) acc = acc ^ p;
            p = gf_mul_a(p);
        end
        return acc;
    endfunction

    // LFSR feedback and next message register for the symbol on in_data.
    always_comb begin
        accept  = in_valid && in_ready;
        fb      = in_data ^ r1;
        r1_nxt  = r0 ^ gf_mul(fb, G1);
        r0_nxt  = gf_mul(fb, G0);
        msg_nxt = {msg[MW-SYMBOL_WIDTH-1:0], in_data};
    end

    // Control FSM with registered handshake outputs and codeword register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= LOAD;
            cnt          <= '0;
            r0           <= '0;
            r1           <= '0;
            msg          <= '0;
            in_ready     <= 1'b1;
            out_valid    <= 1'b0;
            out_codeword <= '0;
        end else if (abort) begin
            // Drop everything in flight; the codeword register keeps its last value.
            state     <= LOAD;
            cnt       <= '0;
            r0        <= '0;
            r1        <= '0;
            msg       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (accept) begin
                        if (cnt == CNT_W'(K-1)) begin
                            out_codeword <= {msg_nxt, r1_nxt, r0_nxt};
                            state        <= HOLD;
                            cnt          <= '0;
                            r0           <= '0;
                            r1           <= '0;
                            msg          <= '0;
                            in_ready     <= 1'b0;
                            out_valid    <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                            r0  <= r0_nxt;
                            r1  <= r1_nxt;
                            msg <= msg_nxt;
                        end
                    end
                end
                HOLD: begin
                    // New message is accepted from the following cycle on.
                    if (out_ready) begin
                        state     <= LOAD;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

    // Protocol invariants.
    a_stable: assert property (@(posedge clk) disable iff (!reset)
        (out_valid && !out_ready && !abort) |=> $stable(out_codeword));
    a_ready: assert property (@(posedge clk) disable iff (!reset)
        in_ready == !out_valid);
    a_cnt: assert property (@(posedge clk) disable iff (!reset)
        cnt <= CNT_W'(K-1));

endmodule

// File: tb/tb_rs_encoder_serial.sv
// Self-checking bench for rs_encoder_serial. The reference codeword comes from
// polynomial long division over GF(8) in integer form (bit i = alpha^i coeff),
// and every emitted codeword is also checked for zero syndromes at alpha, alpha^2.
module tb_rs_encoder_serial;

    logic        clk = 1'b0;
    logic        reset, abort, in_valid, in_ready, out_valid, out_ready;
    logic [2:0]  in_data;
    logic [20:0] out_codeword;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [20:0] CW_ZERO  = 21'b000_000_000_000_000_000_000;
    localparam logic [20:0] CW_LEAD  = 21'b100_000_000_000_000_011_010;
    localparam logic [20:0] CW_TRAIL = 21'b000_000_000_000_100_011_110;
    localparam logic [14:0] M_LEAD   = 15'b100_000_000_000_000;
    localparam logic [14:0] M_TRAIL  = 15'b000_000_000_000_100;

    rs_encoder_serial dut (
        .clk          (clk),
        .reset        (reset),
        .abort        (abort),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_codeword (out_codeword)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Symbol format <-> integer form (bit i = coefficient of alpha^i).
    function automatic logic [2:0] rev3(input logic [2:0] s);
        return {s[0], s[1], s[2]};
    endfunction

    // Carry-less multiply reduced by x^3+x+1, integer form.
    function automatic logic [2:0] gmul(input logic [2:0] a, input logic [2:0] b);
        logic [4:0] p;
        p = '0;
        for (int i = 0; i < 3; i++) if (b[i]) p = p ^ ({2'b00, a} << i);
        for (int i = 4; i >= 3; i--) if (p[i]) p = p ^ (5'b01011 << (i - 3));
        return p[2:0];
    endfunction

    // m(x)*x^2 divided by g(x); remainder gives the parity symbols.
    function automatic logic [20:0] ref_cw(input logic [14:0] m);
        logic [2:0] c [7];
        logic [2:0] g1, g0, q;
        g1 = rev3(3'b011);
        g0 = rev3(3'b110);
        for (int j = 0; j < 5; j++) c[6-j] = rev3(m[14-3*j -: 3]);
        c[1] = '0;
        c[0] = '0;
        for (int i = 6; i >= 2; i--) begin
            q      = c[i];
            c[i]   = '0;
            c[i-1] = c[i-1] ^ gmul(q, g1);
            c[i-2] = c[i-2] ^ gmul(q, g0);
        end
        return {m, rev3(c[1]), rev3(c[0])};
    endfunction

    // Horner evaluation of the codeword polynomial at x (integer form).
    function automatic logic [2:0] syn(input logic [20:0] cw, input logic [2:0] x);
        logic [2:0] s;
        s = '0;
        for (int i = 0; i < 7; i++) s = gmul(s, x) ^ rev3(cw[20-3*i -: 3]);
        return s;
    endfunction

    // Present one symbol from a negedge and hold until it is taken.
    task automatic push(input logic [2:0] s);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        in_data  = s;
        while (in_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        n_checks++;
        if (guard >= 50) begin
            n_fail++;
            $display("FAIL push_timeout: in_ready=%b required 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 3'($urandom);
    endtask

    task automatic send_msg(input logic [14:0] m, input int max_gap);
        for (int j = 0; j < 5; j++) begin
            repeat ($urandom_range(max_gap, 0)) begin
                in_data = 3'($urandom);
                @(negedge clk);
            end
            push(m[14-3*j -: 3]);
        end
    endtask

    task automatic take();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; abort = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        repeat (2) @(negedge clk);
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b need 1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b need 0", out_valid); end
        n_checks++; if (out_codeword !== 21'h0) begin n_fail++; $display("FAIL reset_codeword: got %h need 0", out_codeword); end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fixed();
        logic [14:0] msgs [3];
        logic [20:0] exps [3];
        msgs[0] = 15'h0;  exps[0] = CW_ZERO;
        msgs[1] = M_LEAD; exps[1] = CW_LEAD;
        msgs[2] = M_TRAIL; exps[2] = CW_TRAIL;
        for (int t = 0; t < 3; t++) begin
            send_msg(msgs[t], 0);
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL fixed%0d_latency: out_valid=%b need 1", t, out_valid); end
            n_checks++; if (out_codeword !== exps[t]) begin n_fail++; $display("FAIL fixed%0d_codeword: got %b need %b", t, out_codeword, exps[t]); end
            n_checks++; if (ref_cw(msgs[t]) !== exps[t]) begin n_fail++; $display("FAIL fixed%0d_model: got %b need %b", t, ref_cw(msgs[t]), exps[t]); end
            take();
            n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL fixed%0d_release: in_ready=%b out_valid=%b need 1/0", t, in_ready, out_valid); end
        end
    endtask

    task automatic test_backpressure();
        logic [14:0] m;
        logic [20:0] exp_cw;
        logic        gap_ok;
        m      = 15'($urandom);
        exp_cw = ref_cw(m);
        gap_ok = 1'b1;
        for (int j = 0; j < 5; j++) begin
            repeat ($urandom_range(4, 1)) begin
                in_data = 3'($urandom);
                @(negedge clk);
                if (in_ready !== 1'b1 || out_valid !== 1'b0) gap_ok = 1'b0;
            end
            push(m[14-3*j -: 3]);
        end
        n_checks++; if (gap_ok !== 1'b1) begin n_fail++; $display("FAIL bp_gap_ready: in_ready dropped during gaps, need 1"); end
        for (int c = 0; c < 10; c++) begin
            n_checks++; if (out_codeword !== exp_cw || out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold%0d: got %h valid %b need %h valid 1", c, out_codeword, out_valid, exp_cw); end
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready%0d: got %b need 0", c, in_ready); end
            @(negedge clk);
        end
        take();
        n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release: in_ready=%b out_valid=%b need 1/0", in_ready, out_valid); end
    endtask

    task automatic test_abort();
        for (int j = 0; j < 3; j++) push(3'($urandom_range(7, 1)));
        abort = 1'b1; in_valid = 1'b1; in_data = 3'($urandom);
        @(negedge clk);
        abort = 1'b0; in_valid = 1'b0;
        n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL abort_load: in_ready=%b out_valid=%b need 1/0", in_ready, out_valid); end
        send_msg(M_LEAD, 1);
        n_checks++; if (out_codeword !== CW_LEAD || out_valid !== 1'b1) begin n_fail++; $display("FAIL abort_resend: got %b need %b", out_codeword, CW_LEAD); end
        take();
        // Abort while a codeword is pending.
        send_msg(15'($urandom), 0);
        abort = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        abort = 1'b0; out_ready = 1'b0;
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL abort_hold: out_valid=%b in_ready=%b need 0/1", out_valid, in_ready); end
        send_msg(M_TRAIL, 0);
        n_checks++; if (out_codeword !== CW_TRAIL) begin n_fail++; $display("FAIL abort_hold_resend: got %b need %b", out_codeword, CW_TRAIL); end
        take();
    endtask

    task automatic test_reset_mid();
        for (int j = 0; j < 2; j++) push(3'($urandom_range(7, 1)));
        #2 reset = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid: out_valid=%b in_ready=%b need 0/1", out_valid, in_ready); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        send_msg(M_LEAD, 1);
        n_checks++; if (out_codeword !== CW_LEAD) begin n_fail++; $display("FAIL rst_mid_resend: got %b need %b", out_codeword, CW_LEAD); end
        // Reset while holding a codeword.
        #2 reset = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0 || out_codeword !== 21'h0) begin n_fail++; $display("FAIL rst_hold: out_valid=%b cw=%h need 0/0", out_valid, out_codeword); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        send_msg(M_LEAD, 0);
        n_checks++; if (out_codeword !== CW_LEAD) begin n_fail++; $display("FAIL rst_hold_resend: got %b need %b", out_codeword, CW_LEAD); end
        take();
    endtask

    task automatic test_random();
        logic [14:0] m;
        logic [20:0] exp_cw;
        for (int t = 0; t < 100; t++) begin
            m      = 15'($urandom);
            exp_cw = ref_cw(m);
            send_msg(m, 2);
            n_checks++; if (out_valid !== 1'b1 || out_codeword !== exp_cw) begin n_fail++; $display("FAIL rand%0d_codeword: got %h valid %b need %h", t, out_codeword, out_valid, exp_cw); end
            n_checks++; if (syn(out_codeword, 3'b010) !== 3'b000 || syn(out_codeword, 3'b100) !== 3'b000) begin n_fail++; $display("FAIL rand%0d_syndrome: got %b/%b need 000/000", t, syn(out_codeword, 3'b010), syn(out_codeword, 3'b100)); end
            repeat ($urandom_range(3, 0)) @(negedge clk);
            take();
        end
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_backpressure();
        test_abort();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
